// File: rtl/lrf_wb_arbiter.sv
// Two-port LRF writeback arbiter: round-robin scan, same-address conflict skip, registered writes.
// Define LRF_WB_STATS_EN to build the saturating grant/stall statistics counters.
module lrf_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*5-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wen0,
  output logic [4:0]                wr_addr0,
  output logic [DATA_W-1:0]         wr_data0,
  output logic                      wen1,
  output logic [4:0]                wr_addr1,
  output logic [DATA_W-1:0]         wr_data1,
  output logic [15:0]               stat_grants,
  output logic [15:0]               stat_stalls
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][4:0]        w_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_data;
  assign w_addr = req_addr;
  assign w_data = req_data;

  logic [IW-1:0] r_rr_ptr;
  logic          w_g0_vld, w_g1_vld;
  logic [IW-1:0] w_g0_idx, w_g1_idx, w_last_idx;
  logic [IW:0]   w_nxt_ptr;
  logic [NUM_REQ-1:0] w_ready;
`ifdef LRF_WB_STATS_EN
  logic          w_conflict;
`endif

  // Scan from rr_ptr; a candidate sharing port 0's nonzero address is skipped, not granted.
  always_comb begin
    logic [IW:0]   v_sum;
    logic [IW-1:0] v_idx;
    logic          v_skip;
    w_g0_vld = 1'b0;
    w_g1_vld = 1'b0;
    w_g0_idx = '0;
    w_g1_idx = '0;
`ifdef LRF_WB_STATS_EN
    w_conflict = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (v_sum >= (IW+1)'(NUM_REQ)) v_sum = v_sum - (IW+1)'(NUM_REQ);
      v_idx  = v_sum[IW-1:0];
      v_skip = (w_addr[v_idx] != 5'd0) && (w_addr[v_idx] == w_addr[w_g0_idx]);
      if (!reset && !flush && req_valid[v_idx] && !w_g1_vld) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0_idx = v_idx;
        end else if (v_skip) begin
`ifdef LRF_WB_STATS_EN
          w_conflict = 1'b1;
`endif
        end else begin
          w_g1_vld = 1'b1;
          w_g1_idx = v_idx;
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_g0_vld) w_ready[w_g0_idx] = 1'b1;
    if (w_g1_vld) w_ready[w_g1_idx] = 1'b1;
  end
  assign req_ready = w_ready;

  assign w_last_idx = w_g1_vld ? w_g1_idx : w_g0_idx;
  assign w_nxt_ptr  = {1'b0, w_last_idx} + (IW+1)'(1);

  logic              r_wen0, r_wen1;
  logic [4:0]        r_wr_addr0, r_wr_addr1;
  logic [DATA_W-1:0] r_wr_data0, r_wr_data1;

  // Address-0 grants complete the handshake but never write, and leave addr/data holding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_wen0     <= 1'b0;
      r_wen1     <= 1'b0;
      r_wr_addr0 <= '0;
      r_wr_addr1 <= '0;
      r_wr_data0 <= '0;
      r_wr_data1 <= '0;
    end else begin
      r_wen0 <= w_g0_vld && (w_addr[w_g0_idx] != 5'd0);
      r_wen1 <= w_g1_vld && (w_addr[w_g1_idx] != 5'd0);
      if (w_g0_vld && (w_addr[w_g0_idx] != 5'd0)) begin
        r_wr_addr0 <= w_addr[w_g0_idx];
        r_wr_data0 <= w_data[w_g0_idx];
      end
      if (w_g1_vld && (w_addr[w_g1_idx] != 5'd0)) begin
        r_wr_addr1 <= w_addr[w_g1_idx];
        r_wr_data1 <= w_data[w_g1_idx];
      end
      if (w_g0_vld)
        r_rr_ptr <= (w_nxt_ptr == (IW+1)'(NUM_REQ)) ? '0 : w_nxt_ptr[IW-1:0];
    end
  end

  assign wen0     = r_wen0;
  assign wen1     = r_wen1;
  assign wr_addr0 = r_wr_addr0;
  assign wr_addr1 = r_wr_addr1;
  assign wr_data0 = r_wr_data0;
  assign wr_data1 = r_wr_data1;

`ifdef LRF_WB_STATS_EN
  logic [15:0] r_stat_grants, r_stat_stalls;
  logic [16:0] w_grant_sum;
  assign w_grant_sum = {1'b0, r_stat_grants} + 17'(w_g0_vld) + 17'(w_g1_vld);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_grants <= '0;
      r_stat_stalls <= '0;
    end else begin
      r_stat_grants <= w_grant_sum[16] ? 16'hFFFF : w_grant_sum[15:0];
      if (w_conflict && (r_stat_stalls != 16'hFFFF))
        r_stat_stalls <= r_stat_stalls + 16'd1;
    end
  end

  assign stat_grants = r_stat_grants;
  assign stat_stalls = r_stat_stalls;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_lrf_wb_arbiter.sv
// Directed bench for lrf_wb_arbiter (NUM_REQ=4); stat expectations follow LRF_WB_STATS_EN.
module tb_lrf_wb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
`ifdef LRF_WB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk   = 1'b0;
  logic                 reset = 1'b1;
  logic                 flush = 1'b0;
  logic [N-1:0]         valid = '0;
  logic [N-1:0][4:0]    t_addr = '0;
  logic [N-1:0][DW-1:0] t_data = '0;
  logic [N-1:0]         req_ready;
  logic                 wen0, wen1;
  logic [4:0]           wr_addr0, wr_addr1;
  logic [DW-1:0]        wr_data0, wr_data1;
  logic [15:0]          stat_grants, stat_stalls;

  int          chk   = 0;
  int          fails = 0;
  logic [15:0] exp_g = '0;
  logic [15:0] exp_s = '0;

  lrf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(valid), .req_addr(t_addr), .req_data(t_data), .req_ready(req_ready),
    .wen0(wen0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wen1(wen1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dval(input int i, input logic [4:0] a);
    return 32'hDA00_0000 | (32'(i) << 8) | 32'(a);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [4:0] a0, a1, a2, a3);
    valid = v;
    t_addr[0] = a0; t_addr[1] = a1; t_addr[2] = a2; t_addr[3] = a3;
    for (int i = 0; i < N; i++) t_data[i] = dval(i, t_addr[i]);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    chk++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    tick; tick;
    chk++;
    if ({wen0, wen1, wr_addr0, wr_addr1, wr_data0, wr_data1} !== '0) begin
      fails++; $display("FAIL reset_outputs: wen %b%b addr %0d/%0d data %h/%h expected all 0",
                        wen0, wen1, wr_addr0, wr_addr1, wr_data0, wr_data1);
    end
    chk++;
    if ({stat_grants, stat_stalls} !== 32'd0) begin
      fails++; $display("FAIL reset_stats: got %h/%h expected 0/0", stat_grants, stat_stalls);
    end
    reset = 1'b0;
    valid = '0;
    tick;
  endtask

  task automatic test_basic;
    drive(4'b0011, 5'd3, 5'd7, 5'd0, 5'd0);
    #1;
    chk++;
    if (req_ready !== 4'b0011) begin
      fails++; $display("FAIL basic_ready: got %b expected 0011", req_ready);
    end
    tick;
    chk++;
    if ({wen0, wr_addr0, wr_data0} !== {1'b1, 5'd3, dval(0, 5'd3)}) begin
      fails++; $display("FAIL basic_port0: got %b/%0d/%h expected 1/3/%h", wen0, wr_addr0, wr_data0, dval(0, 5'd3));
    end
    chk++;
    if ({wen1, wr_addr1, wr_data1} !== {1'b1, 5'd7, dval(1, 5'd7)}) begin
      fails++; $display("FAIL basic_port1: got %b/%0d/%h expected 1/7/%h", wen1, wr_addr1, wr_data1, dval(1, 5'd7));
    end
    // pointer should now be 2: requesters 2 and 3 win
    drive(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    chk++;
    if (req_ready !== 4'b1100) begin
      fails++; $display("FAIL basic_rrptr2: got %b expected 1100", req_ready);
    end
    tick;
    chk++;
    if ({wen0, wr_addr0, wr_data0, wen1, wr_addr1, wr_data1} !==
        {1'b1, 5'd3, dval(2, 5'd3), 1'b1, 5'd4, dval(3, 5'd4)}) begin
      fails++; $display("FAIL basic_second_writes: got %0d:%h %0d:%h expected 3:%h 4:%h",
                        wr_addr0, wr_data0, wr_addr1, wr_data1, dval(2, 5'd3), dval(3, 5'd4));
    end
    valid = '0;
    tick;
    chk++;
    if ({wen0, wen1, wr_addr0, wr_data0} !== {2'b00, 5'd3, dval(2, 5'd3)}) begin
      fails++; $display("FAIL idle_hold: got wen %b%b addr0 %0d data0 %h expected 00/3/%h",
                        wen0, wen1, wr_addr0, wr_data0, dval(2, 5'd3));
    end
    exp_g = exp_g + 16'd4;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_rdy [4];
    int           first   [4];
    logic [N-1:0] seen;
    exp_rdy[0] = 4'b0011; exp_rdy[1] = 4'b1100; exp_rdy[2] = 4'b0011; exp_rdy[3] = 4'b1100;
    first[0] = 0; first[1] = 2; first[2] = 0; first[3] = 2;
    seen = '0;
    drive(4'b1111, 5'd10, 5'd11, 5'd12, 5'd13);
    for (int c = 0; c < 4; c++) begin
      #1;
      seen = seen | req_ready;
      chk++;
      if (req_ready !== exp_rdy[c]) begin
        fails++; $display("FAIL rr_ready_c%0d: got %b expected %b", c, req_ready, exp_rdy[c]);
      end
      if (c == 1) begin
        chk++;
        if (seen !== 4'b1111) begin
          fails++; $display("FAIL rr_fairness: granted set %b expected 1111", seen);
        end
      end
      tick;
      chk++;
      if ({wen0, wr_addr0, wr_data0, wen1, wr_addr1, wr_data1} !==
          {1'b1, t_addr[first[c]], dval(first[c], t_addr[first[c]]),
           1'b1, t_addr[first[c]+1], dval(first[c]+1, t_addr[first[c]+1])}) begin
        fails++; $display("FAIL rr_writes_c%0d: got %0d/%0d expected %0d/%0d", c,
                          wr_addr0, wr_addr1, t_addr[first[c]], t_addr[first[c]+1]);
      end
    end
    valid = '0;
    tick;
    exp_g = exp_g + 16'd8;
  endtask

  task automatic test_conflict;
    drive(4'b0111, 5'd5, 5'd5, 5'd9, 5'd0);
    #1;
    chk++;
    if (req_ready !== 4'b0101) begin
      fails++; $display("FAIL conflict_ready: got %b expected 0101", req_ready);
    end
    tick;
    chk++;
    if ({wen0, wr_addr0, wr_data0, wen1, wr_addr1, wr_data1} !==
        {1'b1, 5'd5, dval(0, 5'd5), 1'b1, 5'd9, dval(2, 5'd9)}) begin
      fails++; $display("FAIL conflict_writes: got %b%b %0d:%h %0d:%h expected 11 5:%h 9:%h",
                        wen0, wen1, wr_addr0, wr_data0, wr_addr1, wr_data1, dval(0, 5'd5), dval(2, 5'd9));
    end
    valid = 4'b0010;
    #1;
    chk++;
    if (req_ready !== 4'b0010) begin
      fails++; $display("FAIL conflict_retry_ready: got %b expected 0010", req_ready);
    end
    tick;
    chk++;
    if ({wen0, wr_addr0, wr_data0, wen1} !== {1'b1, 5'd5, dval(1, 5'd5), 1'b0}) begin
      fails++; $display("FAIL conflict_retry_write: got %b/%0d/%h wen1 %b expected 1/5/%h wen1 0",
                        wen0, wr_addr0, wr_data0, wen1, dval(1, 5'd5));
    end
    valid = '0;
    exp_g = exp_g + 16'd3;
    exp_s = exp_s + 16'd1;
    chk++;
    if (stat_stalls !== (STATS ? exp_s : 16'd0)) begin
      fails++; $display("FAIL conflict_stalls: got %0d expected %0d", stat_stalls, STATS ? exp_s : 16'd0);
    end
    chk++;
    if (stat_grants !== (STATS ? exp_g : 16'd0)) begin
      fails++; $display("FAIL conflict_grants: got %0d expected %0d", stat_grants, STATS ? exp_g : 16'd0);
    end
  endtask

  task automatic test_zero_addr;
    drive(4'b0001, 5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    chk++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL zero_ready: got %b expected 0001", req_ready);
    end
    tick;
    exp_g = exp_g + 16'd1;
    chk++;
    if ({wen0, wen1, wr_addr0, wr_data0} !== {2'b00, 5'd5, dval(1, 5'd5)}) begin
      fails++; $display("FAIL zero_nowrite: got wen %b%b addr0 %0d data0 %h expected 00/5/%h",
                        wen0, wen1, wr_addr0, wr_data0, dval(1, 5'd5));
    end
    chk++;
    if (stat_grants !== (STATS ? exp_g : 16'd0)) begin
      fails++; $display("FAIL zero_grants: got %0d expected %0d", stat_grants, STATS ? exp_g : 16'd0);
    end
    // two address-0 requests are not a conflict
    valid = 4'b0011;
    #1;
    chk++;
    if (req_ready !== 4'b0011) begin
      fails++; $display("FAIL zero_pair_ready: got %b expected 0011", req_ready);
    end
    tick;
    exp_g = exp_g + 16'd2;
    chk++;
    if ({wen0, wen1, stat_stalls, stat_grants} !==
        {2'b00, (STATS ? exp_s : 16'd0), (STATS ? exp_g : 16'd0)}) begin
      fails++; $display("FAIL zero_pair: got wen %b%b stalls %0d grants %0d expected 00 %0d %0d",
                        wen0, wen1, stat_stalls, stat_grants, STATS ? exp_s : 16'd0, STATS ? exp_g : 16'd0);
    end
    valid = '0;
  endtask

  task automatic test_flush;
    drive(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
    flush = 1'b1;
    #1;
    chk++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL flush_ready: got %b expected 0000", req_ready);
    end
    tick;
    chk++;
    if ({wen0, wen1} !== 2'b00) begin
      fails++; $display("FAIL flush_wen: got %b%b expected 00", wen0, wen1);
    end
    flush = 1'b0;
    #1;
    chk++;
    if (req_ready !== 4'b0110) begin
      fails++; $display("FAIL flush_rrptr_kept: got %b expected 0110", req_ready);
    end
    tick;
    exp_g = exp_g + 16'd2;
    chk++;
    if ({wen0, wr_addr0, wr_data0, wen1, wr_addr1, wr_data1} !==
        {1'b1, 5'd2, dval(1, 5'd2), 1'b1, 5'd3, dval(2, 5'd3)}) begin
      fails++; $display("FAIL flush_after_writes: got %0d:%h %0d:%h expected 2:%h 3:%h",
                        wr_addr0, wr_data0, wr_addr1, wr_data1, dval(1, 5'd2), dval(2, 5'd3));
    end
  endtask

  task automatic test_reset_mid;
    #1;
    chk++;
    if (req_ready !== 4'b1001) begin
      fails++; $display("FAIL mid_ready: got %b expected 1001", req_ready);
    end
    tick;
    chk++;
    if ({wen0, wr_addr0, wen1, wr_addr1} !== {1'b1, 5'd4, 1'b1, 5'd1}) begin
      fails++; $display("FAIL mid_writes: got %b/%0d %b/%0d expected 1/4 1/1", wen0, wr_addr0, wen1, wr_addr1);
    end
    reset = 1'b1;
    #1;
    chk++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL mid_reset_ready: got %b expected 0000", req_ready);
    end
    tick;
    chk++;
    if ({wen0, wen1, wr_addr0, wr_addr1, wr_data0, wr_data1, stat_grants, stat_stalls} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: wen %b%b addr %0d/%0d stats %0d/%0d expected all 0",
                        wen0, wen1, wr_addr0, wr_addr1, stat_grants, stat_stalls);
    end
    reset = 1'b0;
    #1;
    chk++;
    if (req_ready !== 4'b0011) begin
      fails++; $display("FAIL mid_rrptr_cleared: got %b expected 0011", req_ready);
    end
    valid = '0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_conflict;
    test_zero_addr;
    test_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
